rr_mux_arb: RTL and testbench
=============================

// Module: rr_mux_arb
// PURPOSE
//  Parametrised N:1 data multiplexer with round-robin arbitration and a registered output stage.
//  Each channel presents data under a valid/ready handshake. One granted channel per cycle is loaded into the output register.
//  Sits between multiple RAM/bus requesters and a single shared consumer; replaces fixed-select muxing.
// PARAMETERS
//  N      8   number of input channels (N >= 2)
//  W      16  data width per channel
//  SEL_W  $clog2(N)  localparam, width of channel index
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  rst        in   1      synchronous, active-high reset
//  in_data    in   N*W    channel i occupies bits [i*W +: W]
//  in_valid   in   N      per-channel request/valid
//  in_last    in   N      per-channel end-of-burst flag (used only with ARB_LOCK_EN)
//  in_ready   out  N      per-channel accept; at most one bit set per cycle
//  out_data   out  W      registered selected data
//  out_valid  out  1      out_data holds an undelivered beat
//  out_ready  in   1      consumer accept
//  out_sel    out  SEL_W  index of channel that produced out_data
//  out_last   out  1      registered in_last of that beat
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=0, lock=0; any held beat is discarded.
//  - Combinational in_ready is 0 while rst=1.
//  - load_ok = ~out_valid | out_ready. Transfer on channel i when in_valid[i] & in_ready[i].
//  - Grant: the first channel with in_valid set, scanning from ptr upward and wrapping past N-1 to 0.
//  - in_ready[i] = load_ok & grant[i]. in_ready is combinational from in_valid, out_valid, out_ready and state.
//  - On transfer from channel k: out_data<=in_data[k], out_sel<=k, out_last<=in_last[k], out_valid<=1.
//  - On transfer, ptr<=(k==N-1)?0:k+1. Wrap is exact for non-power-of-2 N.
//  - Drain without load (out_valid & out_ready, no transfer): out_valid<=0. Data and sel keep their values.
//  - Simultaneous drain and load: new beat replaces old beat in the same edge. Throughput is 1 beat/cycle.
//  - Latency: 1 cycle from the input transfer edge to out_valid.
//  - While out_valid & ~out_ready: out_data, out_sel and out_last are stable, and all in_ready bits are 0.
//  - No in_valid set: no grant, and ptr is unchanged.
//  - Fairness: a continuously requesting channel waits at most N-1 beats.
//  - in_valid may drop without a transfer; there is no input-side storage.
// CONFIGURATION
//  Macro ARB_LOCK_EN (burst lock).
//  - Defined:
//    - Transfer from k with in_last[k]=0 sets lock=1 and lock_ch=k.
//    - While lock=1, grant is forced to lock_ch. Other channels see in_ready=0 even if lock_ch is idle.
//    - Transfer with in_last=1 clears lock and advances ptr to k+1.
//    - ptr does not advance on non-last beats.
//    - Reset clears lock.
//  - Undefined: in_last is only registered to out_last. Arbitration advances after every beat, and no lock state exists.
// TESTING
//  1. Reset, single channel: rst 2 cycles, in_valid=8'h04, in_data ch2=16'hA5A5, out_ready=1.
//     -> in_ready=8'h04; next cycle out_valid=1, out_data=A5A5, out_sel=2.
//  2. All request, ready high: in_valid=8'hFF, ch i data=16'h1000+i.
//     -> out_sel sequence 0,1,...,7,0 on consecutive cycles; 1 beat/cycle.
//  3. Backpressure: out_ready=0 with out_valid=1 for 3 cycles.
//     -> out_data stable and in_ready=0 throughout. On out_ready=1, the next beat loads in the same edge.
//  4. Wrap and skip: N=5 build, ptr at 4, in_valid=5'b00011.
//     -> grant ch0, then ch1, then ch0.
//  5. Reset mid-operation: out_valid=1 holding 16'hBEEF, rst=1 for 1 cycle.
//     -> out_valid=0, out_data=0, out_sel=0; next grant starts at ch0.
//  6. ARB_LOCK_EN: ch3 sends 3 beats (last on 3rd) while ch5 requests; ch3 idles one cycle mid-burst.
//     -> ch5 in_ready=0 until ch3's last beat; ch5 is granted on the next cycle.

Source files
------------

// File: rtl/rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb
// Description : N:1 data multiplexer with round-robin arbitration and a
//               registered output stage. One granted channel per cycle is
//               loaded into the output register under valid/ready handshakes.
//               Optional burst lock is enabled by defining ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb #(
   parameter  int N     = 8,
   parameter  int W     = 16,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*W-1:0]     in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic [W-1:0]       out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_last
);

   localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(N - 1);

   logic [SEL_W-1:0] r_ptr;
   logic [W-1:0]     r_out_data;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_out_sel;
   logic             r_out_last;

`ifdef ARB_LOCK_EN
   logic             r_lock;
   logic [SEL_W-1:0] r_lock_ch;
`endif

   logic             w_load_ok;
   logic             w_found;
   logic [SEL_W-1:0] w_gidx;
   logic             w_xfer;
   logic [SEL_W-1:0] w_next_ptr;
   logic [W-1:0]     w_sel_data;
   logic             w_sel_last;

   // The output register can accept a beat when empty or being drained.
   assign w_load_ok  = ~r_out_valid | out_ready;
   assign w_xfer     = ~rst & w_load_ok & w_found;
   assign w_next_ptr = (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;

   // Grant search: scan from ptr upward with exact wrap at N-1; the loop runs
   // downward so the closest requester to ptr is the last one written.
   always_comb begin
      int               w_idx;
      logic [SEL_W-1:0] w_cand;
      w_found = 1'b0;
      w_gidx  = r_ptr;
      w_idx   = 0;
      w_cand  = '0;
      for (int j = N - 1; j >= 0; j--) begin
         w_idx = int'(r_ptr) + j;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         w_cand = SEL_W'(w_idx);
         if (in_valid[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
`ifdef ARB_LOCK_EN
      // A burst in progress pins the grant to its channel, even when idle.
      if (r_lock) begin
         w_found = in_valid[r_lock_ch];
         w_gidx  = r_lock_ch;
      end
`endif
   end

   // Select data and last flag of the granted channel.
   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w_gidx == SEL_W'(i)) begin
            w_sel_data = in_data[i*W +: W];
            w_sel_last = in_last[i];
         end
      end
   end

   generate
      for (genvar i = 0; i < N; i++) begin : g_ready
         assign in_ready[i] = w_xfer & (w_gidx == SEL_W'(i));
      end
   endgenerate

   // Output register: load on transfer, clear valid on drain without load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_sel   <= w_gidx;
         r_out_last  <= w_sel_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Arbitration state: pointer advance and optional burst lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
`ifdef ARB_LOCK_EN
         r_lock    <= 1'b0;
         r_lock_ch <= '0;
`endif
      end else if (w_xfer) begin
`ifdef ARB_LOCK_EN
         if (w_sel_last) begin
            r_lock <= 1'b0;
            r_ptr  <= w_next_ptr;
         end else begin
            r_lock    <= 1'b1;
            r_lock_ch <= w_gidx;
         end
`else
         r_ptr <= w_next_ptr;
`endif
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;
   assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arb
// Description : Self-checking bench for rr_mux_arb (N=8 main instance plus an
//               N=5 instance for wrap checks), scoreboard-based.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arb;
   localparam int N = 8;
   localparam int W = 16;

   typedef struct {
      logic [2:0]  sel;
      logic [15:0] data;
      logic        last;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_last, in_ready;
   logic [W-1:0]   out_data;
   logic           out_valid, out_ready, out_last;
   logic [2:0]     out_sel;

   logic [5*W-1:0] d5_data;
   logic [4:0]     d5_valid, d5_last, d5_ready;
   logic [W-1:0]   d5_odata;
   logic           d5_ovalid, d5_olast;
   logic [2:0]     d5_osel;

   beat_t q[$];
   int    ncmp  = 0;
   int    nfail = 0;
   logic  m_ov;
   int    m_ptr;
   logic  m_lock;
   int    m_lockch;

   always #5 clk = ~clk;

   rr_mux_arb #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .out_last(out_last)
   );

   rr_mux_arb #(.N(5), .W(W)) dut5 (
      .clk(clk), .rst(rst), .in_data(d5_data), .in_valid(d5_valid),
      .in_last(d5_last), .in_ready(d5_ready), .out_data(d5_odata),
      .out_valid(d5_ovalid), .out_ready(1'b1), .out_sel(d5_osel),
      .out_last(d5_olast)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check DUT against the model just after the falling edge,
   // then advance the model across the rising edge.
   task automatic step();
      logic       load_ok, found;
      int         g;
      logic [7:0] er;
      beat_t      b;
      #1;
      found = 1'b0;
      g     = 0;
      if (rst) begin
         er = 8'h00;
      end else begin
         load_ok = !m_ov || out_ready;
`ifdef ARB_LOCK_EN
         if (m_lock) begin
            found = in_valid[m_lockch];
            g     = m_lockch;
         end else
`endif
         begin
            for (int j = 0; j < N; j++) begin
               if (!found && in_valid[(m_ptr + j) % N]) begin
                  found = 1'b1;
                  g     = (m_ptr + j) % N;
               end
            end
         end
         er = (load_ok && found) ? 8'(1 << g) : 8'h00;
      end
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov && q.size() > 0) begin
         b = q[0];
         chk("out_sel", 32'(out_sel), 32'(b.sel));
         chk("out_data", 32'(out_data), 32'(b.data));
         chk("out_last", 32'(out_last), 32'(b.last));
         if (out_ready) void'(q.pop_front());
      end
      if (rst) begin
         q.delete();
         m_ov   = 1'b0;
         m_ptr  = 0;
         m_lock = 1'b0;
      end else if (er != 8'h00) begin
         b.sel  = 3'(g);
         b.data = in_data[g*W +: W];
         b.last = in_last[g];
         q.push_back(b);
         m_ov = 1'b1;
`ifdef ARB_LOCK_EN
         if (in_last[g]) begin
            m_lock = 1'b0;
            m_ptr  = (g + 1) % N;
         end else begin
            m_lock   = 1'b1;
            m_lockch = g;
         end
`else
         m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_last = '1; in_data = '0; out_ready = 1'b0;
      d5_valid = '0; d5_last = '1; d5_data = '0;
      m_ov = 1'b0; m_ptr = 0; m_lock = 1'b0; m_lockch = 0;
      @(negedge clk);
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);

      // Single channel after reset
      rst = 1'b0; out_ready = 1'b1; in_valid = 8'h04;
      in_data[2*W +: W] = 16'hA5A5;
      step();
      in_valid = 8'h00;
      step();
      chk("t1_sel", 32'(out_sel), 32'd2);
      chk("t1_data", 32'(out_data), 32'hA5A5);

      // Wrap and skip on the N=5 instance: ptr to 4 via ch3, then 0,1,0
      for (int i = 0; i < 5; i++) d5_data[i*W +: W] = 16'(16'h5000 + i);
      d5_valid = 5'b01000;
      #1 chk("w5_ready_ch3", 32'(d5_ready), 32'h08);
      step();
      d5_valid = 5'b00011;
      #1 chk("w5_ready0", 32'(d5_ready), 32'h01);
      step();
      #1 chk("w5_ready1", 32'(d5_ready), 32'h02);
      chk("w5_sel0", 32'(d5_osel), 32'd0);
      step();
      #1 chk("w5_ready2", 32'(d5_ready), 32'h01);
      chk("w5_sel1", 32'(d5_osel), 32'd1);
      step();
      d5_valid = 5'b00000;
      chk("w5_sel2", 32'(d5_osel), 32'd0);
      chk("w5_data2", 32'(d5_odata), 32'h5000);

      // All channels requesting from ptr 0: sel 0..7,0 back to back
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'(16'h1000 + i);
      in_valid = 8'hFF;
      for (int c = 0; c < 9; c++) begin
         step();
         chk("t2_sel", 32'(out_sel), 32'(c % 8));
         chk("t2_data", 32'(out_data), 32'(16'h1000 + (c % 8)));
      end

      // Backpressure: output holds ch0 beat, nothing accepted
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t3_hold_data", 32'(out_data), 32'h1000);
         chk("t3_ready_zero", 32'(in_ready), 32'h00);
      end
      out_ready = 1'b1;
      step();
      chk("t3_resume_sel", 32'(out_sel), 32'd1);

      // Reset with a held beat
      in_valid = 8'h40; in_data[6*W +: W] = 16'hBEEF;
      step();
      in_valid = 8'h00; out_ready = 1'b0;
      step();
      chk("t5_held", 32'(out_data), 32'hBEEF);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_data", 32'(out_data), 32'd0);
      chk("t5_sel", 32'(out_sel), 32'd0);
      in_valid = 8'h81; out_ready = 1'b1;
      #1 chk("t5_first_grant", 32'(in_ready), 32'h01);
      step();

      // Burst from ch3 competing with ch5 (ptr now 1)
      in_data[3*W +: W] = 16'h3333; in_data[5*W +: W] = 16'h5555;
      in_last = 8'h00; in_valid = 8'h28;
      step();
`ifdef ARB_LOCK_EN
      #1 chk("t6_lock_b2", 32'(in_ready), 32'h08);
`endif
      step();
      in_valid = 8'h20;
`ifdef ARB_LOCK_EN
      #1 chk("t6_idle_block", 32'(in_ready), 32'h00);
`endif
      step();
      in_valid = 8'h28; in_last = 8'h08;
`ifdef ARB_LOCK_EN
      #1 chk("t6_last", 32'(in_ready), 32'h08);
`endif
      step();
      in_valid = 8'h20;
      #1 chk("t6_ch5_grant", 32'(in_ready), 32'h20);
      step();

      // Random traffic against the scoreboard
      for (int c = 0; c < 60; c++) begin
         in_valid  = 8'($urandom);
         in_last   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
         step();
      end

      // Drain
      in_valid = 8'h00; out_ready = 1'b1;
      step(); step();
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
`default_nettype wire
